// File: rtl/cu_defs_pkg.sv
// Shared definitions for the multicycle control unit.
//   - opcode map (numeric values, cast to OPCODE_W at the point of use)
//   - ALU operation encodings (cast to ALUOP_W at the point of use)
//   - FSM state encoding and decoded instruction class
package cu_defs_pkg;

    // Opcode map
    localparam int unsigned OP_LOADI = 0;
    localparam int unsigned OP_MOV   = 1;
    localparam int unsigned OP_ADD   = 2;
    localparam int unsigned OP_SUB   = 3;
    localparam int unsigned OP_AND   = 4;
    localparam int unsigned OP_OR    = 5;
    localparam int unsigned OP_J     = 6;
    localparam int unsigned OP_BEQ   = 7;
    localparam int unsigned OP_LWD   = 8;
    localparam int unsigned OP_LWI   = 9;
    localparam int unsigned OP_SWD   = 10;
    localparam int unsigned OP_SWI   = 11;

    // ALU operation encodings
    localparam int unsigned ALU_FWD = 0;
    localparam int unsigned ALU_ADD = 1;
    localparam int unsigned ALU_AND = 2;
    localparam int unsigned ALU_OR  = 3;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StMem,
        StWb,
        StErr
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu,
        ClsJump,
        ClsBranch,
        ClsLoad,
        ClsStore,
        ClsIllegal
    } op_class_e;

    function automatic logic is_mem_class(input op_class_e cls);
        return (cls == ClsLoad) || (cls == ClsStore);
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode decoder: latched opcode -> instruction class plus the
// static ALU controls for that opcode.
// Ports:
//   op_i          latched opcode (op_q of the FSM)
//   op_class_o    instruction class (ALU, jump, branch, load, store, illegal)
//   aluop_o       ALU operation
//   negate_o      two's-complement operand 2 (SUB, BEQ)
//   alu_source_o  1 = immediate operand (LOADI, LWI, SWI)
module cu_decoder
    import cu_defs_pkg::*;
#(
    parameter int unsigned OPCODE_W = 8,
    parameter int unsigned ALUOP_W  = 3
) (
    input  logic [OPCODE_W-1:0] op_i,
    output op_class_e           op_class_o,
    output logic [ALUOP_W-1:0]  aluop_o,
    output logic                negate_o,
    output logic                alu_source_o
);

    always_comb begin
        op_class_o   = ClsIllegal;
        aluop_o      = ALUOP_W'(ALU_FWD);
        negate_o     = 1'b0;
        alu_source_o = 1'b0;
        case (op_i)
            OPCODE_W'(OP_LOADI): begin
                op_class_o   = ClsAlu;
                alu_source_o = 1'b1;
            end
            OPCODE_W'(OP_MOV): begin
                op_class_o = ClsAlu;
            end
            OPCODE_W'(OP_ADD): begin
                op_class_o = ClsAlu;
                aluop_o    = ALUOP_W'(ALU_ADD);
            end
            OPCODE_W'(OP_SUB): begin
                op_class_o = ClsAlu;
                aluop_o    = ALUOP_W'(ALU_ADD);
                negate_o   = 1'b1;
            end
            OPCODE_W'(OP_AND): begin
                op_class_o = ClsAlu;
                aluop_o    = ALUOP_W'(ALU_AND);
            end
            OPCODE_W'(OP_OR): begin
                op_class_o = ClsAlu;
                aluop_o    = ALUOP_W'(ALU_OR);
            end
            OPCODE_W'(OP_J): begin
                op_class_o = ClsJump;
            end
            OPCODE_W'(OP_BEQ): begin
                // Compare by subtraction; the datapath checks the zero flag.
                op_class_o = ClsBranch;
                aluop_o    = ALUOP_W'(ALU_ADD);
                negate_o   = 1'b1;
            end
            // Memory ops forward the address operand through the ALU.
            OPCODE_W'(OP_LWD): begin
                op_class_o = ClsLoad;
            end
            OPCODE_W'(OP_LWI): begin
                op_class_o   = ClsLoad;
                alu_source_o = 1'b1;
            end
            OPCODE_W'(OP_SWD): begin
                op_class_o = ClsStore;
            end
            OPCODE_W'(OP_SWI): begin
                op_class_o   = ClsStore;
                alu_source_o = 1'b1;
            end
            default: begin
                op_class_o = ClsIllegal;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: accepts one opcode at a time in IDLE, executes it in
// EXEC, stalls in MEM on the data-memory busywait handshake, writes loads back
// in WB, and parks in ERR after a memory timeout until reset.
// Ports:
//   CLK, RESET            clock (rising edge), asynchronous active-high reset
//   instr_valid, opcode   opcode handshake, sampled only in IDLE
//   mem_busywait          data-memory stall, sampled only in MEM
//   instr_ready           IDLE and not in reset
//   pc_write              PC update this cycle
//   reg_write_enable      register file write
//   negate, alu_source,
//   aluop                 ALU controls
//   jump, branch          PC source selects
//   mem_read, mem_write   data-memory requests
//   mem_to_reg            writeback from memory
//   illegal_op            sticky: undefined opcode executed
//   mem_timeout           sticky: memory timeout
module multicycle_control_unit
    import cu_defs_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 8,
    parameter int unsigned ALUOP_W     = 3,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_busywait,
    output logic                instr_ready,
    output logic                pc_write,
    output logic                reg_write_enable,
    output logic                negate,
    output logic                alu_source,
    output logic [ALUOP_W-1:0]  aluop,
    output logic                jump,
    output logic                branch,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                illegal_op,
    output logic                mem_timeout
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYC);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                illegal_q, illegal_d;
    logic                timeout_q, timeout_d;

    op_class_e           dec_class;
    logic [ALUOP_W-1:0]  dec_aluop;
    logic                dec_negate;
    logic                dec_alu_source;

    cu_decoder #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W)
    ) u_decoder (
        .op_i         (op_q),
        .op_class_o   (dec_class),
        .aluop_o      (dec_aluop),
        .negate_o     (dec_negate),
        .alu_source_o (dec_alu_source)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StIdle;
            op_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        cnt_d            = cnt_q;
        illegal_d        = illegal_q;
        timeout_d        = timeout_q;
        instr_ready      = 1'b0;
        pc_write         = 1'b0;
        reg_write_enable = 1'b0;
        negate           = 1'b0;
        alu_source       = 1'b0;
        aluop            = '0;
        jump             = 1'b0;
        branch           = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        mem_to_reg       = 1'b0;

        case (state_q)
            StIdle: begin
                // Reset forces state to IDLE, so ready must be masked explicitly.
                instr_ready = ~RESET;
                if (instr_valid) begin
                    op_d    = opcode;
                    state_d = StExec;
                end
            end

            StExec: begin
                aluop      = dec_aluop;
                negate     = dec_negate;
                alu_source = dec_alu_source;
                case (dec_class)
                    ClsAlu: begin
                        reg_write_enable = 1'b1;
                        pc_write         = 1'b1;
                        state_d          = StIdle;
                    end
                    ClsJump: begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                        state_d  = StIdle;
                    end
                    ClsBranch: begin
                        branch   = 1'b1;
                        pc_write = 1'b1;
                        state_d  = StIdle;
                    end
                    ClsLoad: begin
                        mem_read = 1'b1;
                        cnt_d    = '0;
                        state_d  = StMem;
                    end
                    ClsStore: begin
                        mem_write = 1'b1;
                        cnt_d     = '0;
                        state_d   = StMem;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        pc_write  = 1'b1;
                        state_d   = StIdle;
                    end
                endcase
            end

            StMem: begin
                // Address operands stay selected while the request is held.
                aluop      = dec_aluop;
                negate     = dec_negate;
                alu_source = dec_alu_source;
                mem_read   = (dec_class == ClsLoad);
                mem_write  = (dec_class == ClsStore);
                if (mem_busywait) begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                    if (cnt_q == CntLast) begin
                        timeout_d = 1'b1;
                        state_d   = StErr;
                    end
                end else if (dec_class == ClsStore) begin
                    pc_write = 1'b1;
                    state_d  = StIdle;
                end else begin
                    state_d = StWb;
                end
            end

            StWb: begin
                reg_write_enable = 1'b1;
                mem_to_reg       = 1'b1;
                pc_write         = 1'b1;
                state_d          = StIdle;
            end

            StErr: begin
                state_d = StErr;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    localparam int T = 4;

    logic       CLK;
    logic       RESET;
    logic       instr_valid;
    logic [7:0] opcode;
    logic       mem_busywait;
    logic       instr_ready, pc_write, reg_write_enable, negate, alu_source;
    logic [2:0] aluop;
    logic       jump, branch, mem_read, mem_write, mem_to_reg, illegal_op, mem_timeout;

    multicycle_control_unit #(
        .OPCODE_W    (8),
        .ALUOP_W     (3),
        .TIMEOUT_CYC (T)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .instr_valid      (instr_valid),
        .opcode           (opcode),
        .mem_busywait     (mem_busywait),
        .instr_ready      (instr_ready),
        .pc_write         (pc_write),
        .reg_write_enable (reg_write_enable),
        .negate           (negate),
        .alu_source       (alu_source),
        .aluop            (aluop),
        .jump             (jump),
        .branch           (branch),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_to_reg       (mem_to_reg),
        .illegal_op       (illegal_op),
        .mem_timeout      (mem_timeout)
    );

    typedef struct packed {
        logic       ready;
        logic       pcw;
        logic       rwe;
        logic       neg;
        logic       src;
        logic [2:0] aluop;
        logic       jump;
        logic       branch;
        logic       mrd;
        logic       mwr;
        logic       m2r;
        logic       ill;
        logic       tmo;
    } exp_t;

    int    checks = 0;
    int    errors = 0;
    exp_t  want;
    exp_t  act;
    logic  want_on = 1'b0;
    string cur_name = "none";
    logic  ill_m, tmo_m;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single compare process: every negedge with an expectation armed.
    always @(negedge CLK) begin
        if (want_on) begin
            act = {instr_ready, pc_write, reg_write_enable, negate, alu_source, aluop,
                   jump, branch, mem_read, mem_write, mem_to_reg, illegal_op, mem_timeout};
            checks++;
            if (act !== want) begin
                errors++;
                $display("FAIL %s t=%0t got=%b want=%b (rdy pcw rwe neg src aluop j b rd wr m2r ill tmo)",
                         cur_name, $time, act, want);
            end
        end
    end

    task automatic pin(input string nm, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, req);
        end
    endtask

    function automatic exp_t base();
        exp_t e;
        e     = '0;
        e.ill = ill_m;
        e.tmo = tmo_m;
        return e;
    endfunction

    // ALU controls per opcode, straight from the opcode map.
    function automatic exp_t with_alu(input exp_t e_in, input logic [7:0] op);
        exp_t e;
        e = e_in;
        case (op)
            8'd0:    begin e.aluop = 3'b000; e.src = 1'b1; end
            8'd1:    e.aluop = 3'b000;
            8'd2:    e.aluop = 3'b001;
            8'd3:    begin e.aluop = 3'b001; e.neg = 1'b1; end
            8'd4:    e.aluop = 3'b010;
            8'd5:    e.aluop = 3'b011;
            8'd7:    begin e.aluop = 3'b001; e.neg = 1'b1; end
            8'd9:    e.src = 1'b1;
            8'd11:   e.src = 1'b1;
            default: e.aluop = 3'b000;
        endcase
        return e;
    endfunction

    task automatic cyc(input exp_t e);
        want    = e;
        want_on = 1'b1;
        @(negedge CLK);
        #1;
    endtask

    task automatic edge_step();
        @(posedge CLK);
        #1;
    endtask

    // One instruction from IDLE. nbusy: busy MEM cycles before ready;
    // rst_at >= 0 asserts RESET when that many busy MEM cycles have elapsed.
    task automatic run(input logic [7:0] op, input int nbusy, input logic exec_busy,
                       input int rst_at, input string nm);
        exp_t e;
        logic is_alu, is_load, is_store;
        int   k;
        is_alu   = (op <= 8'd5);
        is_load  = (op == 8'd8) || (op == 8'd9);
        is_store = (op == 8'd10) || (op == 8'd11);

        cur_name     = {nm, "_idle"};
        instr_valid  = 1'b1;
        opcode       = op;
        mem_busywait = 1'b0;
        e            = base();
        e.ready      = 1'b1;
        cyc(e);
        edge_step();

        // Junk on the opcode bus proves outputs come from the latched opcode.
        cur_name     = {nm, "_exec"};
        instr_valid  = 1'b0;
        opcode       = op ^ 8'h5A;
        mem_busywait = exec_busy;
        e            = with_alu(base(), op);
        if (is_alu) begin
            e.rwe = 1'b1; e.pcw = 1'b1;
        end else if (op == 8'd6) begin
            e.jump = 1'b1; e.pcw = 1'b1;
        end else if (op == 8'd7) begin
            e.branch = 1'b1; e.pcw = 1'b1;
        end else if (is_load) begin
            e.mrd = 1'b1;
        end else if (is_store) begin
            e.mwr = 1'b1;
        end else begin
            e.pcw = 1'b1;
        end
        cyc(e);
        case (op)
            8'd2: begin
                pin("add_aluop", {5'd0, aluop}, 8'h01);
                pin("add_rwe", {7'd0, reg_write_enable}, 8'h01);
                pin("add_pcw", {7'd0, pc_write}, 8'h01);
            end
            8'd3:    pin("sub_negate", {7'd0, negate}, 8'h01);
            8'd0:    pin("loadi_src", {7'd0, alu_source}, 8'h01);
            default: ;
        endcase
        edge_step();
        if (!is_load && !is_store && !is_alu && op != 8'd6 && op != 8'd7) ill_m = 1'b1;
        if (!is_load && !is_store) return;

        k = 0;
        forever begin
            if (k == rst_at) begin
                cur_name = {nm, "_reset_mid_mem"};
                RESET    = 1'b1;
                ill_m    = 1'b0;
                tmo_m    = 1'b0;
                cyc('0);
                edge_step();
                RESET        = 1'b0;
                mem_busywait = 1'b0;
                return;
            end
            cur_name     = {nm, "_mem"};
            mem_busywait = (k < nbusy);
            e            = with_alu(base(), op);
            e.mrd        = is_load;
            e.mwr        = is_store;
            if (k >= nbusy) begin
                e.pcw = is_store;
                cyc(e);
                edge_step();
                break;
            end
            cyc(e);
            edge_step();
            k++;
            if (k == T) begin
                tmo_m = 1'b1;
                break;
            end
        end

        mem_busywait = 1'b0;
        if (tmo_m) begin
            // Stuck in ERR: instr_valid must be ignored.
            cur_name    = {nm, "_err"};
            instr_valid = 1'b1;
            opcode      = 8'd2;
            for (int i = 0; i < 3; i++) begin
                cyc(base());
                edge_step();
            end
            instr_valid = 1'b0;
        end else if (is_load) begin
            cur_name = {nm, "_wb"};
            e        = base();
            e.rwe    = 1'b1;
            e.m2r    = 1'b1;
            e.pcw    = 1'b1;
            cyc(e);
            edge_step();
        end
    endtask

    initial begin
        exp_t e;
        RESET        = 1'b1;
        instr_valid  = 1'b0;
        opcode       = 8'd0;
        mem_busywait = 1'b0;
        ill_m        = 1'b0;
        tmo_m        = 1'b0;

        cur_name = "reset";
        cyc('0);
        pin("reset_ready_gated", {7'd0, instr_ready}, 8'h00);
        edge_step();
        RESET = 1'b0;

        run(8'd2,  0, 1'b0, -1, "add");
        run(8'd3,  0, 1'b0, -1, "sub");
        run(8'd0,  0, 1'b0, -1, "loadi");
        run(8'd8,  2, 1'b1, -1, "lwd_busy");
        run(8'd11, 0, 1'b0, -1, "swi");
        run(8'hFF, 0, 1'b0, -1, "illegal");
        pin("illegal_sticky", {7'd0, illegal_op}, 8'h01);
        run(8'd2,  0, 1'b0, -1, "add_after_ill");
        pin("illegal_still_set", {7'd0, illegal_op}, 8'h01);
        run(8'd9,  T - 1, 1'b0, -1, "lwi_edge");
        run(8'd10, 1, 1'b1, -1, "swd");
        run(8'd7,  0, 1'b0, -1, "beq");
        run(8'd6,  0, 1'b0, -1, "j");
        run(8'd1,  0, 1'b0, -1, "mov");
        run(8'd4,  0, 1'b0, -1, "and");
        run(8'd5,  0, 1'b0, -1, "or");
        run(8'd12, 0, 1'b0, -1, "op12");
        run(8'd8,  100, 1'b0, -1, "lwd_timeout");
        pin("timeout_set", {7'd0, mem_timeout}, 8'h01);
        pin("timeout_read_low", {7'd0, mem_read}, 8'h00);

        cur_name = "err_reset";
        RESET    = 1'b1;
        ill_m    = 1'b0;
        tmo_m    = 1'b0;
        cyc('0);
        edge_step();
        RESET = 1'b0;

        run(8'd8, 100, 1'b0, 2, "lwd_second");

        cur_name = "final_idle";
        e        = base();
        e.ready  = 1'b1;
        cyc(e);
        pin("final_ready", {7'd0, instr_ready}, 8'h01);
        want_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
